// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with fixed wait states and a stall/ready handshake
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [3:0]    cnt;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic          lat_err;

    logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

    logic          req;
    logic          req_write;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    logic          rd_is_load;
    logic          rd_ok;

    // Both strobes together count as a request (timed like a load) but are flagged illegal.
    assign req       = mem_read | mem_write;
    assign req_write = mem_write & ~mem_read;
    assign req_idx   = addr[AW+1:2];
    assign req_err   = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0) || (mem_read && mem_write);

    // With zero wait states DONE is entered straight from IDLE, so the read must use the live inputs.
    assign rd_idx     = (state == IDLE) ? req_idx    : lat_idx;
    assign rd_is_load = (state == IDLE) ? !req_write : !lat_write;
    assign rd_ok      = (state == IDLE) ? !req_err   : !lat_err;

    assign ready = (state == DONE);
    assign err   = (state == DONE) && lat_err;
    assign stall = !rst && (((state == IDLE) && req) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            read_data <= 32'd0;
        end else begin
            if ((state == IDLE) && req) begin
                cnt       <= WAIT_INIT;
                lat_idx   <= req_idx;
                lat_wdata <= write_data;
                lat_write <= req_write;
                lat_err   <= req_err;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if ((next_state == DONE) && (state != DONE) && rd_is_load) begin
                read_data <= rd_ok ? mem[rd_idx] : 32'd0;
            end
        end
    end

    // Memory is never cleared by rst; a reset on the DONE edge suppresses the pending store.
    always_ff @(posedge clk) begin
        if (!rst && (state == DONE) && lat_write && !lat_err) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder (2 and 0 wait states)
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    typedef struct {
        int          inst;
        int          cyc;
        bit          is_load;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mrd [2];
    logic        mwr [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rdd [2];
    logic        rdy [2];
    logic        stl [2];
    logic        er  [2];

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          busy_lo [2];
    int          busy_hi [2];
    bit [31:0]   model [2][DEPTH];
    exp_t        sb [$];
    bit          exp_stall;
    exp_t        head;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mrd[0]), .mem_write(mwr[0]), .addr(ad[0]),
        .write_data(wd[0]), .read_data(rdd[0]), .ready(rdy[0]), .stall(stl[0]), .err(er[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mrd[1]), .mem_write(mwr[1]), .addr(ad[1]),
        .write_data(wd[1]), .read_data(rdd[1]), .ready(rdy[1]), .stall(stl[1]), .err(er[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int waits(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Reference: an access is a single atomic event on a flat word array.
    function automatic exp_t model_access(input int i, input bit rd, input bit wr,
                                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   illegal;
        illegal   = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)) || (rd && wr);
        e.inst    = i;
        e.cyc     = cyc;
        e.is_load = rd;
        e.err     = illegal;
        e.data    = (rd && !illegal) ? model[i][a / 4] : 32'd0;
        if (wr && !rd && !illegal) model[i][a / 4] = d;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic access(input int i, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit noise);
        int w;
        w      = waits(i);
        mrd[i] = rd;
        mwr[i] = wr;
        ad[i]  = a;
        wd[i]  = d;
        sb.push_back(model_access(i, rd, wr, a, d));
        busy_lo[i] = cyc;
        busy_hi[i] = cyc + w;
        for (int k = 0; k <= w; k++) begin
            @(posedge clk); #1;
            if (noise && k < w) begin
                ad[i] = $urandom;
                wd[i] = $urandom;
            end
        end
        @(posedge clk); #1;
        mrd[i] = 1'b0;
        mwr[i] = 1'b0;
    endtask

    task automatic random_access(input int i);
        bit          rd;
        bit          wr;
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        if (r == 0)      a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
        else if (r == 1) a = 32'(DEPTH * 4) + ($urandom_range(0, 63) * 4);
        else if (r == 2) a = 32'(DEPTH * 4 - 4);
        else             a = $urandom_range(0, 15) * 4;
        r  = $urandom_range(0, 9);
        rd = (r < 5) || (r == 9);
        wr = (r >= 5);
        access(i, rd, wr, a, $urandom, bit'($urandom_range(0, 1)));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_stall = !rst && (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
            check($sformatf("stall%0d", i), 32'(stl[i]), 32'(exp_stall));
            if (rdy[i] === 1'b1) begin
                if (sb.size() == 0 || sb[0].inst != i) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready%0d: got=1 want=0 (cycle %0d)", i, cyc);
                end else begin
                    head = sb.pop_front();
                    check($sformatf("latency%0d", i), 32'(cyc - head.cyc), 32'(waits(i) + 1));
                    check($sformatf("err%0d", i), 32'(er[i]), 32'(head.err));
                    if (head.is_load) check($sformatf("read_data%0d", i), rdd[i], head.data);
                end
            end else begin
                check($sformatf("err_idle%0d", i), 32'(er[i]), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mrd[i] = 1'b1;
            mwr[i] = 1'b0;
            ad[i]  = 32'd0;
            wd[i]  = 32'd0;
            busy_lo[i] = 1;
            busy_hi[i] = 0;
            for (int j = 0; j < DEPTH; j++) model[i][j] = 32'd0;
        end
        repeat (3) begin @(posedge clk); #1; end
        check("reset_read_data0", rdd[0], 32'd0);
        check("reset_read_data1", rdd[1], 32'd0);
        check("reset_ready0", 32'(rdy[0]), 32'd0);
        check("reset_ready1", 32'(rdy[1]), 32'd0);
        rst    = 1'b0;
        mrd[1] = 1'b0;

        access(0, 1, 0, 32'h10, 32'h0, 0);
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
        access(0, 1, 0, 32'h10, 32'h0, 0);

        // Store aborted by reset while waiting.
        mrd[0] = 1'b0; mwr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h1234;
        busy_lo[0] = cyc;
        busy_hi[0] = cyc + 2;
        @(posedge clk); #1;
        rst = 1'b1;
        busy_hi[0] = cyc;
        mwr[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_read_data_cleared", rdd[0], 32'd0);
        access(0, 1, 0, 32'h20, 32'h0, 0);

        access(0, 0, 1, 32'h0, 32'hA5A5_0001, 0);
        access(0, 1, 0, 32'h12, 32'h0, 0);
        access(0, 0, 1, 32'(DEPTH * 4), 32'hBAD0_BAD0, 0);
        access(0, 1, 0, 32'h0, 32'h0, 0);
        access(0, 1, 1, 32'h0, 32'h5555_AAAA, 0);
        access(0, 1, 0, 32'h0, 32'h0, 0);
        access(0, 0, 1, 32'h40, 32'hC0FF_EE00, 1);
        access(0, 1, 0, 32'h40, 32'h0, 1);
        access(0, 0, 1, 32'(DEPTH * 4 - 4), 32'h7777_0123, 0);
        access(0, 1, 0, 32'(DEPTH * 4 - 4), 32'h0, 0);
        access(0, 1, 0, 32'h0, 32'h0, 0);
        repeat (30) random_access(0);

        for (int k = 0; k < 4; k++) access(1, 0, 1, 32'(k * 4), $urandom, 0);
        for (int k = 0; k < 4; k++) access(1, 1, 0, 32'(k * 4), 32'h0, 0);
        repeat (20) random_access(1);

        repeat (4) begin @(posedge clk); #1; end
        check("pending_responses", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
